// File: rtl/rmt_pkg.sv
// Shared RMT pipeline constants and the queue-bitmap helper used by the output dispatcher.
package rmt_pkg;

    localparam int PHV_LEN_DEF      = 32*64+256;
    localparam int QUEUE_OFF_DEF    = 141;
    localparam int C_NUM_QUEUES_DEF = 4;
    localparam int MAX_QUEUES       = 16;

    typedef logic [MAX_QUEUES-1:0] qmask_t;

    // Two's-complement trick: bm & -bm keeps only the lowest set bit.
    function automatic qmask_t lowest_set(input qmask_t bm);
        return bm & (~bm + qmask_t'(1));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that either saturates at all-ones or wraps, with a synchronous clear.
module sat_counter #(
    parameter int WIDTH    = 32,
    parameter bit SATURATE = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            if (SATURATE && (r_count == '1)) begin
                r_count <= r_count;
            end else begin
                r_count <= r_count + WIDTH'(1);
            end
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/phv_queue_dispatch.sv
// Steers each accepted PHV to the output queues named by its bitmap; multicast completes
// per queue. Handshake: a transfer happens on any edge where valid && ready are both high.
module phv_queue_dispatch
    import rmt_pkg::*;
#(
    parameter int PHV_LEN      = PHV_LEN_DEF,
    parameter int C_NUM_QUEUES = C_NUM_QUEUES_DEF,
    parameter int QUEUE_OFF    = QUEUE_OFF_DEF,
    parameter bit MCAST_EN     = 1'b1,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                              axis_clk,
    input  logic                              aresetn,
    input  logic [PHV_LEN-1:0]                phv_in,
    input  logic                              phv_in_valid,
    output logic                              phv_in_ready,
    output logic [PHV_LEN-1:0]                phv_out,
    output logic [C_NUM_QUEUES-1:0]           phv_out_valid,
    input  logic [C_NUM_QUEUES-1:0]           phv_fifo_ready,
    output logic [CNT_WIDTH-1:0]              drop_cnt,
    output logic [C_NUM_QUEUES*CNT_WIDTH-1:0] deliv_cnt
);

    generate
        if (QUEUE_OFF + C_NUM_QUEUES > PHV_LEN) begin : g_bad_offset
            $error("phv_queue_dispatch: queue bitmap lies outside the PHV");
        end
        if (C_NUM_QUEUES < 1 || C_NUM_QUEUES > MAX_QUEUES) begin : g_bad_queues
            $error("phv_queue_dispatch: C_NUM_QUEUES must be 1..16");
        end
    endgenerate

    logic [PHV_LEN-1:0]      r_phv;
    logic [C_NUM_QUEUES-1:0] r_pending;

    logic [C_NUM_QUEUES-1:0] w_bm_raw;
    qmask_t                  w_bm_ext;
    qmask_t                  w_bm_low;
    logic [C_NUM_QUEUES-1:0] w_bm;
    logic                    w_bm_nz;
    logic                    w_done_now;
    logic                    w_accept;
    logic                    w_drop;
    logic [C_NUM_QUEUES-1:0] w_complete;

    assign w_bm_raw = phv_in[QUEUE_OFF +: C_NUM_QUEUES];

    always_comb begin
        w_bm_ext                   = '0;
        w_bm_ext[C_NUM_QUEUES-1:0] = w_bm_raw;
    end

    assign w_bm_low = lowest_set(w_bm_ext);
    assign w_bm     = (MCAST_EN != 1'b0) ? w_bm_raw : w_bm_low[C_NUM_QUEUES-1:0];
    // Isolating the lowest bit never turns a nonzero bitmap into zero, so either form works here.
    assign w_bm_nz  = (MCAST_EN != 1'b0) ? (|w_bm_raw) : (|w_bm_low);

    // Ready may be taken in the same cycle the last outstanding queue drains.
    assign w_done_now = ((r_pending & ~phv_fifo_ready) == '0);
    assign w_accept   = phv_in_valid && w_done_now;
    assign w_drop     = w_accept && !w_bm_nz;
    assign w_complete = r_pending & phv_fifo_ready;

    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            r_phv     <= '0;
            r_pending <= '0;
        end else if (w_accept) begin
            if (w_bm_nz) begin
                r_phv <= phv_in;
            end
            r_pending <= w_bm;
        end else begin
            r_pending <= r_pending & ~phv_fifo_ready;
        end
    end

    assign phv_in_ready  = w_done_now;
    assign phv_out       = r_phv;
    assign phv_out_valid = r_pending;

    sat_counter #(
        .WIDTH    (CNT_WIDTH),
        .SATURATE (1'b1)
    ) u_drop_cnt (
        .i_clk   (axis_clk),
        .i_rst_n (aresetn),
        .i_inc   (w_drop),
        .i_clr   (1'b0),
        .o_count (drop_cnt)
    );

    genvar q;
    generate
        for (q = 0; q < C_NUM_QUEUES; q++) begin : g_deliv
            sat_counter #(
                .WIDTH    (CNT_WIDTH),
                .SATURATE (1'b0)
            ) u_deliv_cnt (
                .i_clk   (axis_clk),
                .i_rst_n (aresetn),
                .i_inc   (w_complete[q]),
                .i_clr   (1'b0),
                .o_count (deliv_cnt[q*CNT_WIDTH +: CNT_WIDTH])
            );
        end
    endgenerate

endmodule

// File: tb/tb_phv_queue_dispatch.sv
// Bench for phv_queue_dispatch: multicast, unicast-only and 4-bit-counter instances share one stimulus bus.
module tb_phv_queue_dispatch;

    localparam int PL   = 32*64+256;
    localparam int QOFF = 141;

    logic          clk = 1'b0;
    logic          aresetn = 1'b0;
    logic [PL-1:0] phv_in = '0;
    logic          phv_in_valid = 1'b0;
    logic [3:0]    fifo_rdy = 4'h0;

    logic          rdy_m, rdy_u, rdy_s;
    logic [PL-1:0] out_m, out_u, out_s;
    logic [3:0]    vld_m, vld_u, vld_s;
    logic [31:0]   drop_m, drop_u;
    logic [3:0]    drop_s;
    logic [127:0]  deliv_m, deliv_u;
    logic [15:0]   deliv_s;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    phv_queue_dispatch #(.PHV_LEN(PL), .C_NUM_QUEUES(4), .QUEUE_OFF(QOFF), .MCAST_EN(1'b1), .CNT_WIDTH(32)) u_dut_m (
        .axis_clk(clk), .aresetn(aresetn), .phv_in(phv_in), .phv_in_valid(phv_in_valid),
        .phv_in_ready(rdy_m), .phv_out(out_m), .phv_out_valid(vld_m), .phv_fifo_ready(fifo_rdy),
        .drop_cnt(drop_m), .deliv_cnt(deliv_m));

    phv_queue_dispatch #(.PHV_LEN(PL), .C_NUM_QUEUES(4), .QUEUE_OFF(QOFF), .MCAST_EN(1'b0), .CNT_WIDTH(32)) u_dut_u (
        .axis_clk(clk), .aresetn(aresetn), .phv_in(phv_in), .phv_in_valid(phv_in_valid),
        .phv_in_ready(rdy_u), .phv_out(out_u), .phv_out_valid(vld_u), .phv_fifo_ready(fifo_rdy),
        .drop_cnt(drop_u), .deliv_cnt(deliv_u));

    phv_queue_dispatch #(.PHV_LEN(PL), .C_NUM_QUEUES(4), .QUEUE_OFF(QOFF), .MCAST_EN(1'b1), .CNT_WIDTH(4)) u_dut_s (
        .axis_clk(clk), .aresetn(aresetn), .phv_in(phv_in), .phv_in_valid(phv_in_valid),
        .phv_in_ready(rdy_s), .phv_out(out_s), .phv_out_valid(vld_s), .phv_fifo_ready(fifo_rdy),
        .drop_cnt(drop_s), .deliv_cnt(deliv_s));

    function automatic logic [PL-1:0] rand_phv(input logic [3:0] bm);
        logic [PL-1:0] v;
        for (int i = 0; i < PL; i += 32) v[i +: 32] = $urandom();
        v[QOFF +: 4] = bm;
        return v;
    endfunction

    function automatic logic [3:0] lowest_bit(input logic [3:0] bm);
        for (int b = 0; b < 4; b++) if (bm[b]) return 4'(1 << b);
        return 4'h0;
    endfunction

    // Driver: one reset edge, returns on the following falling edge with all inputs idle.
    task automatic do_reset();
        phv_in_valid = 1'b0;
        fifo_rdy     = 4'h0;
        aresetn      = 1'b0;
        @(negedge clk);
        aresetn      = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_tests++; if (vld_m !== 4'h0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0000", vld_m); end
        n_tests++; if (rdy_m !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", rdy_m); end
        n_tests++; if (out_m !== '0) begin n_fail++; $display("FAIL reset_phv_out: got low %h expected 0", out_m[127:0]); end
        n_tests++; if (drop_m !== 32'd0) begin n_fail++; $display("FAIL reset_drop: got %0d expected 0", drop_m); end
        n_tests++; if (deliv_m !== 128'd0) begin n_fail++; $display("FAIL reset_deliv: got %h expected 0", deliv_m); end
        @(negedge clk);
    endtask

    task automatic test_unicast_stream();
        logic [PL-1:0] cur, prev;
        logic [3:0]    bm, prev_bm;
        do_reset();
        fifo_rdy = 4'hF;
        prev = '0; prev_bm = 4'h0;
        for (int k = 0; k < 8; k++) begin
            bm = 4'(1 << (k % 4));
            cur = rand_phv(bm);
            phv_in = cur; phv_in_valid = 1'b1;
            #1;
            n_tests++; if (rdy_m !== 1'b1) begin n_fail++; $display("FAIL uni_ready[%0d]: got %b expected 1", k, rdy_m); end
            if (k > 0) begin
                n_tests++; if (vld_m !== prev_bm) begin n_fail++; $display("FAIL uni_valid[%0d]: got %b expected %b", k, vld_m, prev_bm); end
                n_tests++; if (out_m !== prev) begin n_fail++; $display("FAIL uni_phv[%0d]: got low %h expected low %h", k, out_m[127:0], prev[127:0]); end
            end
            prev = cur; prev_bm = bm;
            @(negedge clk);
        end
        phv_in_valid = 1'b0;
        #1;
        n_tests++; if (vld_m !== prev_bm) begin n_fail++; $display("FAIL uni_valid_last: got %b expected %b", vld_m, prev_bm); end
        @(negedge clk);
        #1;
        n_tests++; if (vld_m !== 4'h0) begin n_fail++; $display("FAIL uni_idle: got %b expected 0000", vld_m); end
        for (int q = 0; q < 4; q++) begin
            n_tests++; if (deliv_m[q*32 +: 32] !== 32'd2) begin n_fail++; $display("FAIL uni_deliv[%0d]: got %0d expected 2", q, deliv_m[q*32 +: 32]); end
        end
        @(negedge clk);
    endtask

    task automatic test_mcast_backpressure();
        logic [PL-1:0] a, b;
        logic [3:0]    exp_v;
        do_reset();
        a = rand_phv(4'b1011);
        b = rand_phv(4'b0100);
        phv_in = a; phv_in_valid = 1'b1; fifo_rdy = 4'hF;
        @(negedge clk);
        phv_in = b; fifo_rdy = 4'b0011;
        for (int c = 0; c < 3; c++) begin
            #1;
            exp_v = (c == 0) ? 4'b1011 : 4'b1000;
            n_tests++; if (vld_m !== exp_v) begin n_fail++; $display("FAIL mc_valid[%0d]: got %b expected %b", c, vld_m, exp_v); end
            n_tests++; if (rdy_m !== 1'b0) begin n_fail++; $display("FAIL mc_ready[%0d]: got %b expected 0", c, rdy_m); end
            n_tests++; if (out_m !== a) begin n_fail++; $display("FAIL mc_hold[%0d]: got low %h expected low %h", c, out_m[127:0], a[127:0]); end
            @(negedge clk);
        end
        fifo_rdy = 4'hF;
        #1;
        n_tests++; if (vld_m !== 4'b1000) begin n_fail++; $display("FAIL mc_valid_final: got %b expected 1000", vld_m); end
        n_tests++; if (rdy_m !== 1'b1) begin n_fail++; $display("FAIL mc_ready_final: got %b expected 1", rdy_m); end
        @(negedge clk);
        phv_in_valid = 1'b0;
        #1;
        n_tests++; if (vld_m !== 4'b0100) begin n_fail++; $display("FAIL mc_next_valid: got %b expected 0100", vld_m); end
        n_tests++; if (out_m !== b) begin n_fail++; $display("FAIL mc_next_phv: got low %h expected low %h", out_m[127:0], b[127:0]); end
        @(negedge clk);
        #1;
        for (int q = 0; q < 4; q++) begin
            n_tests++; if (deliv_m[q*32 +: 32] !== 32'd1) begin n_fail++; $display("FAIL mc_deliv[%0d]: got %0d expected 1", q, deliv_m[q*32 +: 32]); end
        end
        @(negedge clk);
    endtask

    task automatic test_empty_bitmap();
        logic [3:0]    bms[4];
        logic [PL-1:0] exp_out;
        logic [3:0]    prev_bm;
        bms = '{4'h0, 4'h0, 4'b0100, 4'h0};
        do_reset();
        fifo_rdy = 4'hF;
        exp_out = '0; prev_bm = 4'h0;
        for (int k = 0; k < 4; k++) begin
            phv_in = rand_phv(bms[k]); phv_in_valid = 1'b1;
            #1;
            n_tests++; if (vld_m !== prev_bm) begin n_fail++; $display("FAIL empty_valid[%0d]: got %b expected %b", k, vld_m, prev_bm); end
            n_tests++; if (out_m !== exp_out) begin n_fail++; $display("FAIL empty_phv[%0d]: got low %h expected low %h", k, out_m[127:0], exp_out[127:0]); end
            if (bms[k] != 4'h0) exp_out = phv_in;
            prev_bm = bms[k];
            @(negedge clk);
        end
        phv_in_valid = 1'b0;
        #1;
        n_tests++; if (vld_m !== 4'h0) begin n_fail++; $display("FAIL empty_valid_end: got %b expected 0000", vld_m); end
        n_tests++; if (out_m !== exp_out) begin n_fail++; $display("FAIL empty_phv_kept: got low %h expected low %h", out_m[127:0], exp_out[127:0]); end
        n_tests++; if (drop_m !== 32'd3) begin n_fail++; $display("FAIL empty_drop: got %0d expected 3", drop_m); end
        for (int q = 0; q < 4; q++) begin
            n_tests++; if (deliv_m[q*32 +: 32] !== ((q == 2) ? 32'd1 : 32'd0)) begin
                n_fail++; $display("FAIL empty_deliv[%0d]: got %0d expected %0d", q, deliv_m[q*32 +: 32], (q == 2) ? 1 : 0);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_unicast_mode();
        logic [PL-1:0] cur, prev;
        logic [3:0]    bm, prev_bm, exp_v;
        int unsigned   cnt[4];
        do_reset();
        fifo_rdy = 4'hF;
        prev = '0; prev_bm = 4'h0;
        for (int q = 0; q < 4; q++) cnt[q] = 0;
        for (int k = 0; k < 12; k++) begin
            bm = (k == 0) ? 4'b1110 : 4'($urandom_range(1, 15));
            cur = rand_phv(bm);
            phv_in = cur; phv_in_valid = (k < 11);
            #1;
            if (k > 0) begin
                exp_v = lowest_bit(prev_bm);
                n_tests++; if (vld_u !== exp_v) begin n_fail++; $display("FAIL ucast_valid[%0d]: got %b expected %b", k, vld_u, exp_v); end
                n_tests++; if (out_u[QOFF +: 4] !== prev_bm) begin n_fail++; $display("FAIL ucast_field[%0d]: got %b expected %b", k, out_u[QOFF +: 4], prev_bm); end
                n_tests++; if (out_u !== prev) begin n_fail++; $display("FAIL ucast_phv[%0d]: got low %h expected low %h", k, out_u[127:0], prev[127:0]); end
                for (int q = 0; q < 4; q++) if (exp_v[q]) cnt[q]++;
            end
            prev = cur; prev_bm = bm;
            @(negedge clk);
        end
        #1;
        for (int q = 0; q < 4; q++) begin
            n_tests++; if (deliv_u[q*32 +: 32] !== cnt[q]) begin n_fail++; $display("FAIL ucast_deliv[%0d]: got %0d expected %0d", q, deliv_u[q*32 +: 32], cnt[q]); end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [PL-1:0] x;
        do_reset();
        fifo_rdy = 4'hF;
        phv_in = rand_phv(4'h0); phv_in_valid = 1'b1;
        @(negedge clk);
        phv_in = rand_phv(4'b0001);
        @(negedge clk);
        x = rand_phv(4'b1111);
        phv_in = x;
        @(negedge clk);
        phv_in_valid = 1'b0; fifo_rdy = 4'h0;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_tests++; if (vld_m !== 4'hF) begin n_fail++; $display("FAIL rmid_hold[%0d]: got %b expected 1111", c, vld_m); end
            n_tests++; if (rdy_m !== 1'b0) begin n_fail++; $display("FAIL rmid_ready[%0d]: got %b expected 0", c, rdy_m); end
            @(negedge clk);
        end
        n_tests++; if (drop_m !== 32'd1 || deliv_m[31:0] !== 32'd1) begin n_fail++; $display("FAIL rmid_precount: got drop %0d deliv0 %0d expected 1 1", drop_m, deliv_m[31:0]); end
        aresetn = 1'b0; fifo_rdy = 4'hF;
        @(negedge clk);
        aresetn = 1'b1;
        #1;
        n_tests++; if (vld_m !== 4'h0) begin n_fail++; $display("FAIL rmid_valid: got %b expected 0000", vld_m); end
        n_tests++; if (rdy_m !== 1'b1) begin n_fail++; $display("FAIL rmid_ready_after: got %b expected 1", rdy_m); end
        n_tests++; if (out_m !== '0) begin n_fail++; $display("FAIL rmid_phv: got low %h expected 0", out_m[127:0]); end
        n_tests++; if (drop_m !== 32'd0) begin n_fail++; $display("FAIL rmid_drop: got %0d expected 0", drop_m); end
        for (int c = 0; c < 3; c++) begin
            n_tests++; if (deliv_m !== 128'd0) begin n_fail++; $display("FAIL rmid_deliv[%0d]: got %h expected 0", c, deliv_m); end
            @(negedge clk);
            #1;
        end
        @(negedge clk);
    endtask

    task automatic test_saturation();
        int exp_d;
        do_reset();
        fifo_rdy = 4'hF;
        for (int k = 0; k < 20; k++) begin
            phv_in = rand_phv(4'h0); phv_in_valid = 1'b1;
            @(negedge clk);
            exp_d = (k + 1 > 15) ? 15 : k + 1;
            n_tests++; if (drop_s !== 4'(exp_d)) begin n_fail++; $display("FAIL sat_drop[%0d]: got %0d expected %0d", k, drop_s, exp_d); end
        end
        for (int k = 0; k < 17; k++) begin
            phv_in = rand_phv(4'b0001);
            @(negedge clk);
        end
        phv_in_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (deliv_s[3:0] !== 4'd1) begin n_fail++; $display("FAIL wrap_deliv0: got %0d expected 1", deliv_s[3:0]); end
        n_tests++; if (drop_s !== 4'd15) begin n_fail++; $display("FAIL sat_hold: got %0d expected 15", drop_s); end
    endtask

    // Reference model: outstanding destinations as a list of queue numbers.
    task automatic test_random();
        logic [PL-1:0] mdl_phv;
        int            mdl_dest[$];
        int            keep[$];
        int unsigned   mdl_deliv[4];
        int unsigned   mdl_drop;
        logic [3:0]    bm, exp_v;
        logic          exp_r;
        do_reset();
        mdl_phv = '0; mdl_drop = 0;
        for (int q = 0; q < 4; q++) mdl_deliv[q] = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            bm = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            phv_in = rand_phv(bm);
            phv_in_valid = ($urandom_range(0, 3) != 0);
            fifo_rdy = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom_range(0, 15));
            #1;
            exp_v = 4'h0; exp_r = 1'b1;
            foreach (mdl_dest[i]) begin
                exp_v[mdl_dest[i]] = 1'b1;
                if (!fifo_rdy[mdl_dest[i]]) exp_r = 1'b0;
            end
            n_tests++; if (vld_m !== exp_v) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b expected %b", cyc, vld_m, exp_v); end
            n_tests++; if (rdy_m !== exp_r) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b expected %b", cyc, rdy_m, exp_r); end
            n_tests++; if (out_m !== mdl_phv) begin n_fail++; $display("FAIL rnd_phv[%0d]: got low %h expected low %h", cyc, out_m[127:0], mdl_phv[127:0]); end
            n_tests++; if (drop_m !== 32'(mdl_drop)) begin n_fail++; $display("FAIL rnd_drop[%0d]: got %0d expected %0d", cyc, drop_m, mdl_drop); end
            for (int q = 0; q < 4; q++) begin
                n_tests++; if (deliv_m[q*32 +: 32] !== mdl_deliv[q]) begin n_fail++; $display("FAIL rnd_deliv[%0d][%0d]: got %0d expected %0d", cyc, q, deliv_m[q*32 +: 32], mdl_deliv[q]); end
            end
            keep.delete();
            foreach (mdl_dest[i]) begin
                if (fifo_rdy[mdl_dest[i]]) mdl_deliv[mdl_dest[i]]++;
                else keep.push_back(mdl_dest[i]);
            end
            if (phv_in_valid && exp_r) begin
                mdl_dest.delete();
                if (bm == 4'h0) mdl_drop++;
                else begin
                    mdl_phv = phv_in;
                    for (int q = 0; q < 4; q++) if (bm[q]) mdl_dest.push_back(q);
                end
            end else begin
                mdl_dest = keep;
            end
            @(negedge clk);
        end
        phv_in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_unicast_stream();
        test_mcast_backpressure();
        test_empty_bitmap();
        test_unicast_mode();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/phv_queue_dispatch.md
Name: phv_queue_dispatch

Overview:
- Output dispatcher at the tail of the last RMT stage; replaces the fixed 4-way fan-out.
- Takes one PHV per valid/ready handshake from the action engine. Steers it to C_NUM_QUEUES output FIFOs using the one-hot/multi-hot queue bitmap carried in the PHV.
- Unlike the fixed 4-way version, it does not stall on all-queues-ready. It tracks per-queue delivery, so multicast completes incrementally.
- Counts bitmap-empty drops and optionally forces unicast.

Parameters:
- PHV_LEN, 32*64+256, PHV width in bits
- C_NUM_QUEUES, 4, number of output queues (1-16)
- QUEUE_OFF, 141, LSB position of the queue bitmap in the PHV; bitmap is phv[QUEUE_OFF +: C_NUM_QUEUES]
- MCAST_EN, 1, 1 = deliver to every set bit; 0 = deliver only to the lowest set bit
- CNT_WIDTH, 32, width of the drop and per-queue delivery counters

Ports:
- axis_clk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- phv_in  in  PHV_LEN  PHV from the action engine
- phv_in_valid  in  1  phv_in valid
- phv_in_ready  out  1  dispatcher can take phv_in this cycle
- phv_out  out  PHV_LEN  held PHV; shared by all queues
- phv_out_valid  out  C_NUM_QUEUES  per-queue valid; equals the pending mask
- phv_fifo_ready  in  C_NUM_QUEUES  per-queue FIFO ready
- drop_cnt  out  CNT_WIDTH  PHVs dropped for an empty bitmap; saturating
- deliv_cnt  out  C_NUM_QUEUES*CNT_WIDTH  per-queue delivered count, flattened, queue q at [q*CNT_WIDTH +: CNT_WIDTH]; wraps

Behaviour:
- Reset, when aresetn=0 at a clock edge:
  - phv_out=0, pending=0, phv_out_valid=0, drop_cnt=0, all deliv_cnt=0.
  - phv_in_ready=1 once the reset release edge has occurred.
  - A reset mid-delivery discards the held PHV and its remaining destinations. Nothing is replayed.
- Pending mask and output valid:
  - pending[C_NUM_QUEUES-1:0] is registered.
  - phv_out_valid = pending, driven combinationally from the register.
  - Queue q completes when pending[q] && phv_fifo_ready[q]. Its bit clears on the next edge and deliv_cnt[q] increments.
- Input ready:
  - done_now = ((pending & ~phv_fifo_ready) == 0), i.e. every remaining destination completes this cycle (true when pending=0).
  - phv_in_ready = done_now, a combinational path from phv_fifo_ready.
  - Throughput is 1 PHV/cycle while all targeted queues are ready.
- Accept (phv_in_valid && phv_in_ready):
  - bm = phv_in[QUEUE_OFF +: C_NUM_QUEUES].
  - If MCAST_EN=0, bm is reduced to its lowest set bit (bm & -bm).
  - If bm != 0: phv_out <= phv_in, pending <= bm. Latency is 1 cycle, input edge to phv_out_valid.
  - If bm == 0: PHV dropped, drop_cnt += 1 (saturates at all-ones), pending <= 0, phv_out unchanged.
  - phv_out is written unmodified. The bitmap field is passed through as-is, even in unicast mode.
- No accept this cycle: pending <= pending & ~phv_fifo_ready.
- Simultaneous last-destination completion and new accept: the new pending is loaded and the old bits are not ORed in. Zero-bubble back-to-back operation is required.
- phv_out and the pending bits hold stable while the targeted queue is not ready; AXI-style rule, no valid withdrawal.
- Ready without valid on an idle queue has no effect.
- Counter wrap:
  - deliv_cnt wraps modulo 2^CNT_WIDTH.
  - drop_cnt saturates.
  - Both update on the same edge as the event.
- Implicit two-state machine:
  - IDLE (pending=0) -> BUSY on an accept with bm != 0.
  - BUSY -> IDLE when done_now and there is no new accept.
  - BUSY -> BUSY when done_now with an accept of a nonzero bitmap.
- Bitmap bits in the PHV above C_NUM_QUEUES are ignored.
- Elaboration error if QUEUE_OFF + C_NUM_QUEUES > PHV_LEN.

Decomposition:
- Shared package rmt_pkg:
  - PHV_LEN default
  - QUEUE_OFF default (141)
  - C_NUM_QUEUES default
  - function lowest_set(bm) returning the isolated lowest bit
- One natural sub-module, sat_counter (WIDTH, SATURATE parameters; inc/clr), instanced for drop_cnt and for each deliv_cnt.

Test Plan:
- Unicast stream, all queues ready:
  - Stimulus: 8 back-to-back PHVs with bitmap 4'b0001, 0010, 0100, 1000 repeating; phv_fifo_ready=4'hF.
  - Required: one-hot phv_out_valid each cycle, 1-cycle latency, phv_in_ready constantly 1, deliv_cnt = {2,2,2,2}.
- Multicast partial backpressure:
  - Stimulus: bitmap 4'b1011; ready=4'b0011 for 3 cycles, then 4'hF.
  - Required: valid 1011 -> 1000 held 3 cycles -> done; phv_in_ready=0 throughout, 1 on the completing cycle; next PHV loads with no bubble.
- Empty bitmap:
  - Stimulus: 3 PHVs with bitmap 0, interleaved with one bitmap 4'b0100.
  - Required: drop_cnt=3, only queue 2 sees valid, deliv_cnt[2]=1.
- MCAST_EN=0:
  - Stimulus: bitmap 4'b1110.
  - Required: only phv_out_valid=4'b0010; phv_out[144:141] still 1110.
- Reset mid-operation:
  - Stimulus: multicast 4'b1111 held with ready=0; aresetn=0 for 1 cycle.
  - Required: valid=0 and counters 0 on the next cycle, phv_in_ready=1; the old PHV is never delivered.
- Counter saturation:
  - Stimulus: with CNT_WIDTH=4, 20 empty-bitmap drops.
  - Required: drop_cnt=15 and holds.
